target_error_unit: RTL and testbench
====================================

// Module: target_error_unit
// PURPOSE
//  Downstream consumer of the target-row memory stage. On a rising edge of that stage's
//  finish flag, captures the 16-element target row plus the matching prediction row and
//  walks the elements one per cycle. Emits err = pred - target per element on a
//  valid/ready stream and accumulates the sum of |err| for the row for the
//  training/update logic.
// PARAMETERS
//  no_of_elements  16  elements per row (index width = clog2(no_of_elements))
//  element_width   32  signed two's-complement element width
//  acc_width       36  sum-of-abs-error width (element_width + clog2(no_of_elements))
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous active-low reset
//  finish_in    in   1         finish level from the target-row memory; rising edge = new row
//  target_elems in   W*N       target row, element 0 in bits [W*N-1 -: W]
//  pred_elems   in   W*N       prediction row, same packing
//  err_ready    in   1         downstream accepts err_data this cycle
//  err_valid    out  1         err_data/err_idx valid
//  err_data     out  W         saturated pred - target for element err_idx
//  err_idx      out  clog2(N)  element index 0..N-1
//  sum_abs_err  out  acc_width running/final sum of |err_data|
//  busy         out  1         row in progress
//  done         out  1         one-cycle pulse after last element accepted
//  overrun      out  1         sticky: rising edge on finish_in while busy
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, FSM IDLE, idx=0, finish_in edge register=0.
//  - Edge detect: start = finish_in & ~finish_q, finish_q registered every cycle.
//  - FSM IDLE: on start, latch both rows into internal regs, clear sum_abs_err, idx=0,
//    busy=1, go RUN. Inputs are sampled only in that cycle; later changes are ignored.
//  - FSM RUN: err_valid=1; err_data/err_idx are registered and present from the cycle
//    after start (latency 1).
//  - Transfer = err_valid & err_ready. On transfer: sum_abs_err += |err_data|, idx++.
//    On transfer at idx=N-1, go DONE.
//  - err_valid stays high and err_data/err_idx stay stable while err_ready=0.
//  - FSM DONE: busy=0, err_valid=0, done=1 for exactly one cycle, then IDLE.
//    sum_abs_err holds the final value until the next start.
//  - Arithmetic: diff = sext(pred) - sext(target) in W+1 bits, saturated to
//    [-2^(W-1), 2^(W-1)-1]. The accumulator adds |saturated diff|.
//    |-2^(W-1)| is taken as 2^(W-1), which is representable in acc_width; no wrap is possible.
//  - Start while busy (RUN or DONE): ignored, current row continues, overrun<=1.
//    overrun clears only on reset.
//  - Start in the same cycle as DONE: ignored (overrun set). Upstream must re-pulse.
//  - Reset mid-row: immediate abort to IDLE, partial sum discarded (cleared).
//  - Zero-stall throughput: N transfers in N consecutive cycles. done follows one cycle
//    after the last transfer.
// TESTING
//  1 Reset: rst_n=0 mid-RUN -> all outputs 0 asynchronously; after release, FSM IDLE.
//  2 Basic row: target[i]=i, pred[i]=2*i, err_ready=1 -> err_data=0..15, idx=0..15 on
//    consecutive cycles, sum_abs_err=120, done pulse one cycle after idx=15 transfer.
//  3 Back-pressure: err_ready toggles 1,0,0,1,... -> no element lost or duplicated,
//    err_data stable while stalled, final sum identical to scenario 2.
//  4 Saturation: pred[0]=32'h7FFFFFFF, target[0]=32'h80000000 -> err_data=32'h7FFFFFFF.
//    Reversed operands -> 32'h80000000, and sum includes 2^31.
//  5 Overrun: finish_in 0->1->0->1 while busy -> second edge ignored, overrun=1, row
//    output unchanged. finish_in held high for 40 cycles -> only one row processed.
//  6 Negative errors: pred=all 0, target[i]=5 -> err_data=-5 (32'hFFFFFFFB) for all i,
//    sum_abs_err=80.

Source files
------------

// File: rtl/target_error_if.sv
// Purpose : bundles the row inputs, the err stream and the status outputs of target_error_unit.
// Latency : n/a (wires only).
// Backpressure: err_ready (driven by master) stalls the err_valid/err_data/err_idx stream.
// Ports   : finish_in, target_elems, pred_elems, err_ready  (master -> slave)
//           err_valid, err_data, err_idx, sum_abs_err, busy, done, overrun  (slave -> master)
interface target_error_if #(
    parameter int no_of_elements = 16,
    parameter int element_width  = 32,
    parameter int acc_width      = 36
);
    localparam int idx_width = $clog2(no_of_elements);

    logic                                     finish_in;
    logic [element_width*no_of_elements-1:0]  target_elems;
    logic [element_width*no_of_elements-1:0]  pred_elems;
    logic                                     err_ready;
    logic                                     err_valid;
    logic [element_width-1:0]                 err_data;
    logic [idx_width-1:0]                     err_idx;
    logic [acc_width-1:0]                     sum_abs_err;
    logic                                     busy;
    logic                                     done;
    logic                                     overrun;

    modport master (
        output finish_in, target_elems, pred_elems, err_ready,
        input  err_valid, err_data, err_idx, sum_abs_err, busy, done, overrun
    );

    modport slave (
        input  finish_in, target_elems, pred_elems, err_ready,
        output err_valid, err_data, err_idx, sum_abs_err, busy, done, overrun
    );
endinterface

// File: rtl/target_error_unit.sv
// Purpose : on a rising edge of finish_in, latches target/pred rows and streams saturated
//           pred-target per element, accumulating the row's sum of |err|.
// Latency : first element one cycle after the finish_in edge; one element per cycle when unstalled;
//           done one cycle after the last transfer.
// Backpressure: err_ready=0 holds err_valid/err_data/err_idx stable; edges while busy set overrun.
// Ports   : clk, rst_n (async active-low), bus (target_error_if.slave, see interface header).
module target_error_unit #(
    parameter int no_of_elements = 16,
    parameter int element_width  = 32,
    parameter int acc_width      = 36
) (
    input  logic            clk,
    input  logic            rst_n,
    target_error_if.slave   bus
);
    localparam int n  = no_of_elements;
    localparam int w  = element_width;
    localparam int iw = $clog2(no_of_elements);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic            finish_q;
    logic            start;
    logic            xfer;
    logic            last;
    logic [w*n-1:0]  tgt_row;
    logic [w*n-1:0]  pred_row;
    logic [iw-1:0]   idx;
    logic [iw-1:0]   idx_inc;
    logic [w-1:0]    err_q;
    logic [acc_width-1:0] sum_q;
    logic            overrun_q;

    // Element 0 sits in the most significant slot of the packed row.
    function automatic logic [w-1:0] elem(input logic [w*n-1:0] row, input logic [iw-1:0] i);
        return row[(n - 1 - int'(i)) * w +: w];
    endfunction

    // Difference in w+1 bits; if the top two bits disagree the result does not fit in w bits.
    function automatic logic [w-1:0] sat_diff(input logic [w-1:0] p, input logic [w-1:0] t);
        logic [w:0] d;
        d = {p[w-1], p} - {t[w-1], t};
        if (d[w] != d[w-1])
            return d[w] ? {1'b1, {(w-1){1'b0}}} : {1'b0, {(w-1){1'b1}}};
        return d[w-1:0];
    endfunction

    // Magnitude computed in w+1 bits so the most negative value yields +2^(w-1).
    function automatic logic [acc_width-1:0] abs_ext(input logic [w-1:0] e);
        logic [w:0] m;
        m = e[w-1] ? (~{1'b1, e} + 1'b1) : {1'b0, e};
        return {{(acc_width-w-1){1'b0}}, m};
    endfunction

    assign start   = bus.finish_in & ~finish_q;
    assign xfer    = (state == RUN) & bus.err_ready;
    assign last    = (idx == iw'(n - 1));
    assign idx_inc = idx + iw'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q  <= 1'b0;
            tgt_row   <= '0;
            pred_row  <= '0;
            idx       <= '0;
            err_q     <= '0;
            sum_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            finish_q <= bus.finish_in;
            if (state == IDLE && start) begin
                tgt_row  <= bus.target_elems;
                pred_row <= bus.pred_elems;
                idx      <= '0;
                sum_q    <= '0;
                // Element 0 comes straight from the inputs so it is ready one cycle after start.
                err_q    <= sat_diff(elem(bus.pred_elems, '0), elem(bus.target_elems, '0));
            end else if (xfer) begin
                sum_q <= sum_q + abs_ext(err_q);
                idx   <= idx_inc;
                if (!last)
                    err_q <= sat_diff(elem(pred_row, idx_inc), elem(tgt_row, idx_inc));
            end
            if (start && state != IDLE)
                overrun_q <= 1'b1;
        end
    end

    assign bus.err_valid   = (state == RUN);
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.err_data    = err_q;
    assign bus.err_idx     = idx;
    assign bus.sum_abs_err = sum_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_target_error_unit.sv
module tb_target_error_unit;
    localparam int N   = 16;
    localparam int W   = 32;
    localparam int ACC = 36;
    localparam int IW  = $clog2(N);

    logic clk;
    logic rst_n;

    target_error_if #(.no_of_elements(N), .element_width(W), .acc_width(ACC)) bus ();

    target_error_unit #(.no_of_elements(N), .element_width(W), .acc_width(ACC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [W-1:0] tgt [N];
    logic [W-1:0] prd [N];
    logic [W-1:0] exp_err [N];
    longint      exp_sum;
    logic [W-1:0] first_data;
    int          row_cycles;

    // Reference: plain integer subtraction, clamp to the signed W-bit range, sum magnitudes.
    task automatic build_expected();
        longint d;
        exp_sum = 0;
        for (int i = 0; i < N; i++) begin
            d = longint'($signed(prd[i])) - longint'($signed(tgt[i]));
            if (d > 64'sd2147483647)  d = 64'sd2147483647;
            if (d < -64'sd2147483648) d = -64'sd2147483648;
            exp_err[i] = W'(d);
            exp_sum += (d < 0) ? -d : d;
        end
    endtask

    task automatic pack_rows();
        for (int i = 0; i < N; i++) begin
            bus.target_elems[(N-1-i)*W +: W] = tgt[i];
            bus.pred_elems[(N-1-i)*W +: W]   = prd[i];
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic run_row(input int mode, input bit hold, input bit inject);
        int k, cyc;
        bit stalled, fin, rdy;
        logic [W-1:0] prev;
        build_expected();
        @(negedge clk);
        pack_rows();
        bus.finish_in = 1'b1;
        bus.err_ready = 1'b0;
        k = 0; cyc = 0; stalled = 0; fin = 0; prev = '0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                // Inputs change after the capture cycle; the row must already be latched.
                bus.target_elems = {N{$urandom()}};
                bus.pred_elems   = {N{$urandom()}};
                bus.finish_in    = hold;
            end
            if (inject && cyc == 7) bus.finish_in = 1'b1;
            if (inject && cyc == 8) bus.finish_in = 1'b0;
            if (k < N) begin
                checks++;
                if (bus.err_valid !== 1'b1 || bus.err_idx !== IW'(k) || bus.err_data !== exp_err[k]) begin
                    failures++;
                    $display("FAIL elem%0d: valid=%b idx=%0d data=%h, expected valid=1 idx=%0d data=%h",
                             k, bus.err_valid, bus.err_idx, bus.err_data, k, exp_err[k]);
                end
                if (k == 0) first_data = bus.err_data;
                if (stalled) begin
                    checks++;
                    if (bus.err_data !== prev) begin
                        failures++;
                        $display("FAIL stall_stable elem%0d: data=%h, expected %h", k, bus.err_data, prev);
                    end
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ((cyc - 1) % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.err_ready = rdy;
                if (rdy) begin
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = bus.err_data;
                end
            end else if (k == N) begin
                checks++;
                if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err_valid !== 1'b0 ||
                    bus.sum_abs_err !== ACC'(exp_sum)) begin
                    failures++;
                    $display("FAIL row_end: done=%b busy=%b valid=%b sum=%0d, expected done=1 busy=0 valid=0 sum=%0d",
                             bus.done, bus.busy, bus.err_valid, bus.sum_abs_err, exp_sum);
                end
                k++;
                bus.err_ready = 1'($urandom_range(0, 1));
            end else begin
                checks++;
                if (bus.done !== 1'b0) begin
                    failures++;
                    $display("FAIL done_pulse_width: done=%b, expected 0", bus.done);
                end
                fin = 1;
            end
        end
        row_cycles = cyc;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL row_timeout: completed %0d of %0d elements, expected full row", k, N);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.err_valid !== 1'b0 || bus.err_data !== '0 || bus.err_idx !== '0 || bus.sum_abs_err !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s: valid=%b data=%h idx=%0d sum=%0d busy=%b done=%b overrun=%b, expected all 0",
                     name, bus.err_valid, bus.err_data, bus.err_idx, bus.sum_abs_err, bus.busy, bus.done, bus.overrun);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_release");
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) begin tgt[i] = W'(i); prd[i] = W'(2 * i); end
        run_row(0, 0, 0);
        checks++;
        if (bus.sum_abs_err !== ACC'(120) || row_cycles !== N + 2) begin
            failures++;
            $display("FAIL basic_sum: sum=%0d cycles=%0d, expected sum=120 cycles=%0d", bus.sum_abs_err, row_cycles, N + 2);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) begin tgt[i] = W'(i); prd[i] = W'(2 * i); end
        run_row(1, 0, 0);
        checks++;
        if (bus.sum_abs_err !== ACC'(120)) begin
            failures++;
            $display("FAIL backpressure_sum: sum=%0d, expected 120", bus.sum_abs_err);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++) begin tgt[i] = $urandom(); prd[i] = $urandom(); end
        tgt[0] = 32'h80000000;
        prd[0] = 32'h7FFFFFFF;
        run_row(2, 0, 0);
        checks++;
        if (first_data !== 32'h7FFFFFFF) begin
            failures++;
            $display("FAIL sat_pos: data=%h, expected 7fffffff", first_data);
        end
        for (int i = 0; i < N; i++) begin tgt[i] = '0; prd[i] = '0; end
        tgt[0] = 32'h7FFFFFFF;
        prd[0] = 32'h80000000;
        run_row(0, 0, 0);
        checks++;
        if (first_data !== 32'h80000000 || bus.sum_abs_err !== 36'h080000000) begin
            failures++;
            $display("FAIL sat_neg: data=%h sum=%h, expected data=80000000 sum=080000000", first_data, bus.sum_abs_err);
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < N; i++) begin tgt[i] = 32'd5; prd[i] = '0; end
        run_row(1, 0, 0);
        checks++;
        if (first_data !== 32'hFFFFFFFB || bus.sum_abs_err !== ACC'(80)) begin
            failures++;
            $display("FAIL negative: data=%h sum=%0d, expected data=fffffffb sum=80", first_data, bus.sum_abs_err);
        end
    endtask

    task automatic test_held_finish();
        bit bad;
        for (int i = 0; i < N; i++) begin tgt[i] = $urandom(); prd[i] = $urandom(); end
        run_row(0, 1, 0);
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            bus.err_ready = 1'($urandom_range(0, 1));
            if (bus.done !== 1'b0 || bus.err_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL held_finish: extra_activity=%0d overrun=%b, expected 0 and 0", bad, bus.overrun);
        end
        bus.finish_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < N; i++) begin tgt[i] = $urandom(); prd[i] = $urandom(); end
        run_row(0, 0, 1);
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun: overrun=%b, expected 1", bus.overrun);
        end
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                tgt[i] = ($urandom_range(0, 1) == 1) ? $urandom() : W'($urandom_range(0, 1000));
                prd[i] = ($urandom_range(0, 1) == 1) ? $urandom() : W'($urandom_range(0, 1000));
            end
            run_row(2, 0, 0);
        end
    endtask

    task automatic test_reset_midrow();
        for (int i = 0; i < N; i++) begin tgt[i] = $urandom(); prd[i] = $urandom(); end
        build_expected();
        @(negedge clk);
        pack_rows();
        bus.finish_in = 1'b1;
        bus.err_ready = 1'b1;
        @(negedge clk);
        bus.finish_in = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_midrow");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_midrow_reset");
        for (int i = 0; i < N; i++) begin tgt[i] = W'(i); prd[i] = W'(2 * i); end
        run_row(0, 0, 0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.finish_in = 1'b0;
        bus.err_ready = 1'b0;
        bus.target_elems = '0;
        bus.pred_elems   = '0;
        first_data    = '0;
        row_cycles    = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_negative();
        test_held_finish();
        test_overrun();
        test_random_rows();
        test_reset_midrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
